acog_hub_arb: RTL and testbench

//   Hub arbiter and hub-RAM port sitting directly downstream of every cog's sequencer.

---
 rtl/acog_hub_arb.sv | 160 ++++++++++++++++
 tb/tb_acog_hub_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acog_hub_arb.sv
// Round-robin hub arbiter and 32-bit hub RAM port; issue in the cog's slot, ack one cycle later.
// No backpressure: cog requests are held levels until acked and the RAM accepts every access.
module acog_hub_arb #(
  parameter int NUM_COGS = 8,
  parameter int ADDR_W   = 15
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [NUM_COGS-1:0]          cog_read_in,
  input  logic [NUM_COGS-1:0]          cog_write_in,
  input  logic [2*NUM_COGS-1:0]        cog_tfr_sz_in,
  input  logic [ADDR_W*NUM_COGS-1:0]   cog_addr_in,
  input  logic [32*NUM_COGS-1:0]       cog_wdata_in,
  output logic [NUM_COGS-1:0]          cog_ack_o,
  output logic [31:0]                  cog_rdata_o,
  output logic [ADDR_W-3:0]            ram_addr_o,
  output logic                         ram_we_o,
  output logic [3:0]                   ram_be_o,
  output logic [31:0]                  ram_wdata_o,
  input  logic [31:0]                  ram_rdata_in
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam int         SLOT_W  = (NUM_COGS > 1) ? $clog2(NUM_COGS) : 1;

  // Access issued in the previous cycle, completed (acked) in the current one.
  typedef struct packed {
    logic              vld;
    logic              rd;
    logic [SLOT_W-1:0] cog;
    logic [1:0]        off;
    logic [1:0]        sz;
  } pend_t;

  logic [SLOT_W-1:0]   slot;
  logic [NUM_COGS-1:0] served;
  pend_t               pend;
  logic [31:0]         rdata_hold;

  logic [ADDR_W-1:0]   slot_addr;
  logic [1:0]          slot_sz;
  logic [31:0]         slot_wdata;
  logic                slot_rd;
  logic                slot_wr;
  logic                slot_served;
  logic                issue;
  logic [NUM_COGS-1:0] grant_mask;
  logic [31:0]         rd_sel;
  logic                rd_ack;

  // Select the request of the cog owning the current slot.
  always_comb begin
    slot_addr   = '0;
    slot_sz     = '0;
    slot_wdata  = '0;
    slot_rd     = 1'b0;
    slot_wr     = 1'b0;
    slot_served = 1'b0;
    for (int c = 0; c < NUM_COGS; c++) begin
      if (slot == SLOT_W'(c)) begin
        slot_addr   = cog_addr_in[c*ADDR_W +: ADDR_W];
        slot_sz     = cog_tfr_sz_in[2*c +: 2];
        slot_wdata  = cog_wdata_in[32*c +: 32];
        slot_rd     = cog_read_in[c];
        slot_wr     = cog_write_in[c];
        slot_served = served[c];
      end
    end
  end

  assign issue = ~reset_in & (slot_rd | slot_wr) & ~slot_served;

  always_comb begin
    grant_mask = '0;
    for (int c = 0; c < NUM_COGS; c++) begin
      grant_mask[c] = issue && (slot == SLOT_W'(c));
    end
  end

  // RAM port: write wins over read when a cog raises both.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (issue) begin
      ram_addr_o = slot_addr[ADDR_W-1:2];
      if (slot_wr) begin
        ram_we_o = 1'b1;
        case (slot_sz)
          SZ_BYTE: begin
            ram_be_o    = 4'b0001 << slot_addr[1:0];
            ram_wdata_o = {4{slot_wdata[7:0]}};
          end
          SZ_WORD: begin
            ram_be_o    = slot_addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata_o = {2{slot_wdata[15:0]}};
          end
          default: begin
            ram_be_o    = 4'b1111;
            ram_wdata_o = slot_wdata;
          end
        endcase
      end
    end
  end

  // Lane extraction of the RAM read data; size 2'b11 behaves as long.
  always_comb begin
    rd_sel = ram_rdata_in;
    case (pend.sz)
      SZ_BYTE: begin
        case (pend.off)
          2'd0:    rd_sel = {24'h0, ram_rdata_in[7:0]};
          2'd1:    rd_sel = {24'h0, ram_rdata_in[15:8]};
          2'd2:    rd_sel = {24'h0, ram_rdata_in[23:16]};
          default: rd_sel = {24'h0, ram_rdata_in[31:24]};
        endcase
      end
      SZ_WORD: rd_sel = pend.off[1] ? {16'h0, ram_rdata_in[31:16]}
                                    : {16'h0, ram_rdata_in[15:0]};
      default: rd_sel = ram_rdata_in;
    endcase
  end

  // Reset squashes an in-flight completion in the same cycle it is asserted.
  assign rd_ack = pend.vld & pend.rd & ~reset_in;

  always_comb begin
    cog_ack_o = '0;
    for (int c = 0; c < NUM_COGS; c++) begin
      cog_ack_o[c] = pend.vld && !reset_in && (pend.cog == SLOT_W'(c));
    end
  end

  assign cog_rdata_o = reset_in ? 32'h0 : (rd_ack ? rd_sel : rdata_hold);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      slot       <= '0;
      served     <= '0;
      pend       <= '0;
      rdata_hold <= '0;
    end else begin
      slot     <= (slot == SLOT_W'(NUM_COGS-1)) ? '0 : slot + 1'b1;
      // served drops once the sequencer releases both request lines
      served   <= (served & (cog_read_in | cog_write_in)) | grant_mask;
      pend.vld <= issue;
      pend.rd  <= ~slot_wr;
      pend.cog <= slot;
      pend.off <= slot_addr[1:0];
      pend.sz  <= slot_sz;
      if (rd_ack) begin
        rdata_hold <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_acog_hub_arb.sv
// Directed bench for acog_hub_arb with a behavioural hub RAM and an ack scoreboard.
module tb_acog_hub_arb;
  localparam int NC = 8;
  localparam int AW = 15;
  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZW = 2'b01;
  localparam logic [1:0] SZL = 2'b10;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [NC-1:0]   cog_read_in;
  logic [NC-1:0]   cog_write_in;
  logic [2*NC-1:0] cog_tfr_sz_in;
  logic [AW*NC-1:0] cog_addr_in;
  logic [32*NC-1:0] cog_wdata_in;
  logic [NC-1:0]   cog_ack_o;
  logic [31:0]     cog_rdata_o;
  logic [AW-3:0]   ram_addr_o;
  logic            ram_we_o;
  logic [3:0]      ram_be_o;
  logic [31:0]     ram_wdata_o;
  logic [31:0]     ram_rdata_in;

  typedef struct packed {
    logic [2:0]  cog;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          mslot = 0;
  logic [31:0] exp_hold = 32'h0;
  logic [31:0] mem [0:8191] = '{default: 32'h0};

  acog_hub_arb #(.NUM_COGS(NC), .ADDR_W(AW)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .cog_read_in   (cog_read_in),
    .cog_write_in  (cog_write_in),
    .cog_tfr_sz_in (cog_tfr_sz_in),
    .cog_addr_in   (cog_addr_in),
    .cog_wdata_in  (cog_wdata_in),
    .cog_ack_o     (cog_ack_o),
    .cog_rdata_o   (cog_rdata_o),
    .ram_addr_o    (ram_addr_o),
    .ram_we_o      (ram_we_o),
    .ram_be_o      (ram_be_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_in  (ram_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous hub RAM: byte-lane writes, registered read.
  always @(posedge clk_in) begin
    if (ram_we_o && ram_be_o[0]) mem[ram_addr_o][7:0]   <= ram_wdata_o[7:0];
    if (ram_we_o && ram_be_o[1]) mem[ram_addr_o][15:8]  <= ram_wdata_o[15:8];
    if (ram_we_o && ram_be_o[2]) mem[ram_addr_o][23:16] <= ram_wdata_o[23:16];
    if (ram_we_o && ram_be_o[3]) mem[ram_addr_o][31:24] <= ram_wdata_o[31:24];
    ram_rdata_in <= mem[ram_addr_o];
  end

  // Expected slot of the current cycle.
  always @(posedge clk_in) begin
    mslot <= reset_in ? 0 : (mslot + 1) % NC;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_slot(input int s);
    for (int k = 0; k < 16 && mslot != s; k++) step();
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [31:0] d);
    cog_read_in[c]               = rd;
    cog_write_in[c]              = wr;
    cog_tfr_sz_in[2*c +: 2]      = sz;
    cog_addr_in[c*AW +: AW]      = a;
    cog_wdata_in[32*c +: 32]     = d;
  endtask

  task automatic drop(input int c);
    cog_read_in[c]  = 1'b0;
    cog_write_in[c] = 1'b0;
  endtask

  task automatic expect_ack(input int c, input logic rd, input logic [31:0] d);
    exp_t e;
    e.cog  = 3'(c);
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) step();
    check("scoreboard_drain", 32'(sb.size()), 32'h0);
  endtask

  // Ack monitor: every ack must match the oldest expected completion.
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_in) begin
      exp_hold = 32'h0;
    end else if (cog_ack_o != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(cog_ack_o), 32'h0);
      end else begin
        e = sb.pop_front();
        check("ack_vector", 32'(cog_ack_o), 32'h1 << e.cog);
        if (e.rd) begin
          check("read_data", cog_rdata_o, e.data);
          exp_hold = e.data;
        end else begin
          check("rdata_held_on_write", cog_rdata_o, exp_hold);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    reset_in      = 1'b1;
    cog_read_in   = '0;
    cog_write_in  = '0;
    cog_tfr_sz_in = '0;
    cog_addr_in   = '0;
    cog_wdata_in  = '0;
    repeat (3) step();

    @(negedge clk_in);
    check("rst_ack", 32'(cog_ack_o), 32'h0);
    check("rst_rdata", cog_rdata_o, 32'h0);
    check("rst_we", 32'(ram_we_o), 32'h0);
    check("rst_be", 32'(ram_be_o), 32'h0);
    check("rst_addr", 32'(ram_addr_o), 32'h0);
    check("rst_wdata", ram_wdata_o, 32'h0);
    step();
    reset_in = 1'b0;

    // Idle rotation
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_in);
      check("idle_slot", 32'(dut.slot), 32'(k % NC));
      check("idle_we", 32'(ram_we_o), 32'h0);
      check("idle_ack", 32'(cog_ack_o), 32'h0);
      step();
    end

    // Cog 3 long write
    wait_slot(1);
    set_req(3, 1'b0, 1'b1, SZL, 15'h0104, 32'hDEADBEEF);
    expect_ack(3, 1'b0, 32'h0);
    wait_slot(3);
    @(negedge clk_in);
    check("c3_addr", 32'(ram_addr_o), 32'h041);
    check("c3_be", 32'(ram_be_o), 32'hF);
    check("c3_we", 32'(ram_we_o), 32'h1);
    check("c3_wdata", ram_wdata_o, 32'hDEADBEEF);
    step();
    drop(3);
    drain();

    // Cog 0 byte write then byte read
    wait_slot(6);
    set_req(0, 1'b0, 1'b1, SZB, 15'h0006, 32'h123456A5);
    expect_ack(0, 1'b0, 32'h0);
    wait_slot(0);
    @(negedge clk_in);
    check("c0_bw_be", 32'(ram_be_o), 32'h4);
    check("c0_bw_wdata", ram_wdata_o, 32'hA5A5A5A5);
    check("c0_bw_addr", 32'(ram_addr_o), 32'h1);
    step();
    drop(0);
    drain();
    set_req(0, 1'b1, 1'b0, SZB, 15'h0006, 32'h0);
    expect_ack(0, 1'b1, 32'h000000A5);
    wait_slot(0);
    @(negedge clk_in);
    check("c0_br_we", 32'(ram_we_o), 32'h0);
    check("c0_br_addr", 32'(ram_addr_o), 32'h1);
    step();
    drop(0);
    drain();

    // Cog 6 preloads a long, cog 5 word-reads it at an odd address
    set_req(6, 1'b0, 1'b1, SZL, 15'h0010, 32'h12345678);
    expect_ack(6, 1'b0, 32'h0);
    wait_slot(6);
    @(negedge clk_in);
    check("c6_addr", 32'(ram_addr_o), 32'h4);
    step();
    drop(6);
    drain();
    set_req(5, 1'b1, 1'b0, SZW, 15'h0013, 32'h0);
    expect_ack(5, 1'b1, 32'h00001234);
    wait_slot(5);
    @(negedge clk_in);
    check("c5_addr", 32'(ram_addr_o), 32'h4);
    step();
    drop(5);
    drain();

    // Word writes to both halves, then a size-3 (long) read
    set_req(2, 1'b0, 1'b1, SZW, 15'h0022, 32'hBEEFCAFE);
    expect_ack(2, 1'b0, 32'h0);
    wait_slot(2);
    @(negedge clk_in);
    check("c2_ww_be", 32'(ram_be_o), 32'hC);
    check("c2_ww_wdata", ram_wdata_o, 32'hCAFECAFE);
    check("c2_ww_addr", 32'(ram_addr_o), 32'h8);
    step();
    drop(2);
    drain();
    set_req(1, 1'b0, 1'b1, SZW, 15'h0021, 32'h0000BEEF);
    expect_ack(1, 1'b0, 32'h0);
    wait_slot(1);
    @(negedge clk_in);
    check("c1_ww_be", 32'(ram_be_o), 32'h3);
    check("c1_ww_wdata", ram_wdata_o, 32'hBEEFBEEF);
    step();
    drop(1);
    drain();
    check("rdata_hold", cog_rdata_o, 32'h00001234);
    set_req(7, 1'b1, 1'b0, 2'b11, 15'h0021, 32'h0);
    expect_ack(7, 1'b1, 32'hCAFEBEEF);
    wait_slot(7);
    step();
    drop(7);
    drain();

    // Read and write together: write wins
    set_req(4, 1'b1, 1'b1, SZL, 15'h0200, 32'h55AA55AA);
    expect_ack(4, 1'b0, 32'h0);
    wait_slot(4);
    @(negedge clk_in);
    check("c4_rw_we", 32'(ram_we_o), 32'h1);
    check("c4_rw_be", 32'(ram_be_o), 32'hF);
    check("c4_rw_addr", 32'(ram_addr_o), 32'h80);
    check("c4_rw_wdata", ram_wdata_o, 32'h55AA55AA);
    step();
    drop(4);
    drain();

    // All cogs write together, requests held well past their acks
    wait_slot(2);
    s = mslot;
    for (int c = 0; c < NC; c++)
      set_req(c, 1'b0, 1'b1, SZL, AW'((32'h60 + c) * 4), 32'hC0DE0000 | (32'(c) * 32'h1111));
    for (int k = 0; k < NC; k++) expect_ack((s + k) % NC, 1'b0, 32'h0);
    repeat (NC + 1) step();
    for (int c = 0; c < NC; c++) drop(c);
    drain();

    // All cogs read back together
    wait_slot(5);
    s = mslot;
    for (int c = 0; c < NC; c++)
      set_req(c, 1'b1, 1'b0, SZL, AW'((32'h60 + c) * 4), 32'h0);
    for (int k = 0; k < NC; k++)
      expect_ack((s + k) % NC, 1'b1, 32'hC0DE0000 | (32'((s + k) % NC) * 32'h1111));
    repeat (NC + 1) step();
    for (int c = 0; c < NC; c++) drop(c);
    drain();
    repeat (10) step();

    // Reset right after a read issue
    wait_slot(0);
    set_req(1, 1'b1, 1'b0, SZL, 15'h0100, 32'h0);
    step();
    @(negedge clk_in);
    check("c1_rd_we", 32'(ram_we_o), 32'h0);
    check("c1_rd_addr", 32'(ram_addr_o), 32'h40);
    step();
    reset_in = 1'b1;
    drop(1);
    @(negedge clk_in);
    check("rst_mid_ack", 32'(cog_ack_o), 32'h0);
    check("rst_mid_rdata", cog_rdata_o, 32'h0);
    step();
    step();
    reset_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_slot", 32'(dut.slot), 32'h0);
    check("post_rst_rdata", cog_rdata_o, 32'h0);
    check("post_rst_ack", 32'(cog_ack_o), 32'h0);
    repeat (10) step();
    check("final_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
